// File: rtl/credit_lookup_pkg.sv
// Shared types and helpers for the credit lookup engine: combine modes,
// per-beat combine function and credit counter sizing.
package credit_lookup_pkg;

    localparam int unsigned MAX_RAM = 8;
    localparam int unsigned MAX_DW  = 64;

    typedef enum logic [1:0] {
        MODE_SUM    = 2'd0,
        MODE_XOR    = 2'd1,
        MODE_SELECT = 2'd2
    } mode_e;

    typedef logic [MAX_RAM-1:0][MAX_DW-1:0] words_t;

    // Reserved encoding 3 folds onto SUM.
    function automatic mode_e decode_mode(input logic [1:0] tuser);
        case (tuser)
            2'd1:    return MODE_XOR;
            2'd2:    return MODE_SELECT;
            default: return MODE_SUM;
        endcase
    endfunction

    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Unused word slots must be zero so SUM/XOR can sweep all MAX_RAM entries.
    function automatic logic [MAX_DW-1:0] combine(input mode_e       mode,
                                                  input words_t      words,
                                                  input int unsigned num_ram,
                                                  input int unsigned sel);
        logic [MAX_DW-1:0] acc;
        acc = '0;
        case (mode)
            MODE_XOR: begin
                for (int unsigned i = 0; i < MAX_RAM; i++) acc = acc ^ words[i];
            end
            MODE_SELECT: begin
                for (int unsigned i = 0; i < MAX_RAM; i++) begin
                    if (i == sel && i < num_ram) acc = words[i];
                end
            end
            default: begin
                for (int unsigned i = 0; i < MAX_RAM; i++) acc = acc + words[i];
            end
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/cr_fifo_fwft.sv
// First-word-fall-through FIFO with sticky overflow flag; writes into a full
// FIFO are dropped.
module cr_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             r_overflow;
    logic             w_full;
    logic             w_empty;
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra pointer bit distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_wr = i_wr_en & ~w_full;
    assign w_do_rd = i_rd_en & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[PW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_wr_en && w_full) r_overflow <= 1'b1;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr[PW-1:0]];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/credit_lookup_nram.sv
// Credit-controlled parallel RAM lookup: one address per beat fans out to all
// read ports, returned words are combined per beat and queued in an FWFT FIFO.
module credit_lookup_nram
    import credit_lookup_pkg::*;
#(
    parameter int unsigned NUM_RAM    = 2,
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SELW       = (NUM_RAM > 1) ? $clog2(NUM_RAM) : 1
) (
    input  logic                      clk,
    input  logic                      reset_p,
    input  logic [AW+SELW-1:0]        in_tdata,
    input  logic [1:0]                in_tuser,
    input  logic                      in_tlast,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    output logic [NUM_RAM-1:0]        ram_rd_en,
    output logic [NUM_RAM*AW-1:0]     ram_rd_addr,
    input  logic [NUM_RAM*DW-1:0]     ram_rd_data,
    output logic [DW-1:0]             out_tdata,
    output logic                      out_tlast,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output logic                      fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0] credit
);

    localparam int unsigned    CW         = credit_width(FIFO_DEPTH);
    localparam int unsigned    L          = RD_LATENCY;
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH);

    logic            w_accept;
    logic            w_pop;
    logic [CW-1:0]   r_credit;
    logic [CW-1:0]   w_credit_nxt;
    logic [L-1:0]    r_vld;
    logic [L-1:0]    r_last;
    mode_e           r_mode [L];
    logic [SELW-1:0] r_sel  [L];
    words_t          w_words;
    logic [DW-1:0]   w_result;
    logic [DW:0]     w_fifo_rdata;
    logic            w_fifo_empty;
    logic            w_unused_full;

    // Ready depends on registered credit only, never on out_tready.
    assign in_tready   = ~reset_p & (r_credit != '0);
    assign w_accept    = in_tvalid & in_tready;
    assign w_pop       = out_tvalid & out_tready;
    assign ram_rd_en   = {NUM_RAM{w_accept}};
    assign ram_rd_addr = {NUM_RAM{in_tdata[AW-1:0]}};

    always_comb begin
        w_credit_nxt = r_credit;
        case ({w_accept, w_pop})
            2'b10:   if (r_credit != '0) w_credit_nxt = r_credit - 1'b1;
            2'b01:   if (r_credit != CREDIT_MAX) w_credit_nxt = r_credit + 1'b1;
            default: w_credit_nxt = r_credit;
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) r_credit <= CREDIT_MAX;
        else         r_credit <= w_credit_nxt;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int unsigned i = 0; i < L; i++) begin
                r_mode[i] <= MODE_SUM;
                r_sel[i]  <= '0;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_last[0] <= in_tlast;
            r_mode[0] <= decode_mode(in_tuser);
            r_sel[0]  <= in_tdata[AW+SELW-1:AW];
            for (int unsigned i = 1; i < L; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
                r_mode[i] <= r_mode[i-1];
                r_sel[i]  <= r_sel[i-1];
            end
        end
    end

    always_comb begin
        w_words = '0;
        for (int unsigned i = 0; i < NUM_RAM; i++) begin
            w_words[i][DW-1:0] = ram_rd_data[i*DW +: DW];
        end
        w_result = DW'(combine(r_mode[L-1], w_words, NUM_RAM, 32'(r_sel[L-1])));
    end

    cr_fifo_fwft #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (reset_p),
        .i_wr_en    (r_vld[L-1]),
        .i_wr_data  ({r_last[L-1], w_result}),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_rdata),
        .o_full     (w_unused_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (fifo_overflow)
    );

    assign out_tvalid = ~w_fifo_empty;
    assign out_tdata  = w_fifo_rdata[DW-1:0];
    assign out_tlast  = w_fifo_rdata[DW];
    assign credit     = r_credit;

endmodule
